inst_encoder: RTL and testbench

//  Inverse of the instruction decoder: packs opcode/imm/register/func fields into a 32-bit RV32I word.
//  2-stage valid/ready pipeline: S1 classify + check, S2 assemble. Used as the assembler back end in

---
 rtl/rv_isa_pkg.sv | 54 +++++
 rtl/inst_encoder_if.sv | 39 +++
 rtl/inst_enc_check.sv | 50 +++++
 rtl/inst_encoder.sv | 150 +++++++++++++++
 tb/tb_inst_encoder.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_isa_pkg.sv
// Purpose: RV32I opcode constants, instruction format classes and encoder error codes shared
//          by the instruction encoder and its range/format checker.
// Contents:
//   OP_*        5-bit major opcodes (inst[6:2])
//   fmt_e       instruction format class used to select the assembly layout
//   err_code_e  per-word error code (priority bad opcode > misaligned > out of range)
//   opcode_fmt  opcode -> format class lookup
package rv_isa_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_FENCE  = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_REG    = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_SYS,
    FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_OPCODE = 2'b01,
    ERR_ALIGN  = 2'b10,
    ERR_RANGE  = 2'b11
  } err_code_e;

  // FENCE shares the {func12,rs1,func3,rd,op} layout with SYSTEM.
  function automatic fmt_e opcode_fmt(input logic [4:0] op);
    case (op)
      OP_REG:                    return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      OP_SYSTEM, OP_FENCE:       return FMT_SYS;
      default:                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Purpose: request/response bundle of the instruction encoder.
// Signals:
//   in_valid/in_ready    request handshake
//   in_opcode..in_func12 instruction fields (imm is sign-extended, decoder form)
//   out_valid/out_ready  result handshake
//   out_inst/out_err/out_err_code  encoded word and its error status
// Modports: master = requester/consumer side, slave = encoder side.
interface inst_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [11:0] in_func12;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [1:0]  out_err_code;

  modport master (
    output in_valid, in_opcode, in_imm, in_rs1, in_rs2, in_rd, in_func3, in_func7, in_func12,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_err, out_err_code
  );

  modport slave (
    input  in_valid, in_opcode, in_imm, in_rs1, in_rs2, in_rd, in_func3, in_func7, in_func12,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_err, out_err_code
  );

endinterface

// File: rtl/inst_enc_check.sv
// Purpose: combinational classifier for the encoder's first stage. Maps the opcode to a format
//          class and checks the immediate against what that format can represent.
// Ports:
//   opcode    in  5   inst[6:2]
//   imm       in  32  sign-extended immediate
//   fmt       out     format class (FMT_BAD for unknown opcodes)
//   err_code  out     ERR_NONE / ERR_OPCODE / ERR_ALIGN / ERR_RANGE
// RANGE_CHECK=0 reports only bad opcodes; immediates are then truncated by the assembler.
module inst_enc_check
  import rv_isa_pkg::*;
#(
  parameter bit RANGE_CHECK = 1'b1
) (
  input  logic [4:0]  opcode,
  input  logic [31:0] imm,
  output fmt_e        fmt,
  output err_code_e   err_code
);

  logic fits12;  // signed 12-bit (I/S)
  logic fits13;  // signed 13-bit (B)
  logic fits21;  // signed 21-bit (J)

  always_comb begin
    fmt      = opcode_fmt(opcode);
    fits12   = (imm[31:11] == {21{imm[11]}});
    fits13   = (imm[31:12] == {20{imm[12]}});
    fits21   = (imm[31:20] == {12{imm[20]}});
    err_code = ERR_NONE;
    if (fmt == FMT_BAD) begin
      err_code = ERR_OPCODE;
    end else if (RANGE_CHECK) begin
      // Alignment is tested before range so a misaligned, out-of-range word reports ERR_ALIGN.
      case (fmt)
        FMT_I, FMT_S: if (!fits12) err_code = ERR_RANGE;
        FMT_B: begin
          if (imm[0])       err_code = ERR_ALIGN;
          else if (!fits13) err_code = ERR_RANGE;
        end
        FMT_J: begin
          if (imm[0])       err_code = ERR_ALIGN;
          else if (!fits21) err_code = ERR_RANGE;
        end
        FMT_U: if (imm[11:0] != 12'h000) err_code = ERR_ALIGN;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Purpose: packs opcode/imm/register/func fields into a 32-bit RV32I word. Two-stage
//          valid/ready pipeline: S1 registers the fields with their classification and error
//          code, S2 registers the assembled word. Errored words are emitted (as 32'h0 with
//          out_err=1), never dropped, so output order always equals input order.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus               inst_encoder_if.slave request/response bundle
//   cnt_clr           synchronous clear of both counters (wins over an increment)
//   cnt_ok, cnt_err   wrap-around counts of emitted good / errored words
module inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter bit          RANGE_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  inst_encoder_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  fmt_e      chk_fmt;
  err_code_e chk_err;

  logic        s1_valid_q;
  logic [4:0]  s1_op_q;
  logic [31:0] s1_imm_q;
  logic [4:0]  s1_rs1_q, s1_rs2_q, s1_rd_q;
  logic [2:0]  s1_f3_q;
  logic [6:0]  s1_f7_q;
  logic [11:0] s1_f12_q;
  fmt_e        s1_fmt_q;
  err_code_e   s1_err_q;

  logic        out_valid_q;
  logic [31:0] out_inst_q;
  logic        out_err_q;
  logic [1:0]  out_code_q;

  logic [CNT_W-1:0] cnt_ok_q, cnt_err_q;

  logic        s1_load, s2_load, out_fire;
  logic [31:0] asm_inst;

  inst_enc_check #(
    .RANGE_CHECK(RANGE_CHECK)
  ) u_check (
    .opcode  (bus.in_opcode),
    .imm     (bus.in_imm),
    .fmt     (chk_fmt),
    .err_code(chk_err)
  );

  // S2 frees up when empty or draining this cycle; S1 frees up when empty or moving into S2,
  // so both stages advance together under a simultaneous in/out handshake.
  assign s2_load  = !out_valid_q || bus.out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign out_fire = out_valid_q && bus.out_ready;

  assign bus.in_ready     = s1_load;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_inst     = out_inst_q;
  assign bus.out_err      = out_err_q;
  assign bus.out_err_code = out_code_q;
  assign cnt_ok           = cnt_ok_q;
  assign cnt_err          = cnt_err_q;

  // S1: fields plus the classification result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_imm_q   <= '0;
      s1_rs1_q   <= '0;
      s1_rs2_q   <= '0;
      s1_rd_q    <= '0;
      s1_f3_q    <= '0;
      s1_f7_q    <= '0;
      s1_f12_q   <= '0;
      s1_fmt_q   <= FMT_R;
      s1_err_q   <= ERR_NONE;
    end else if (s1_load) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op_q  <= bus.in_opcode;
        s1_imm_q <= bus.in_imm;
        s1_rs1_q <= bus.in_rs1;
        s1_rs2_q <= bus.in_rs2;
        s1_rd_q  <= bus.in_rd;
        s1_f3_q  <= bus.in_func3;
        s1_f7_q  <= bus.in_func7;
        s1_f12_q <= bus.in_func12;
        s1_fmt_q <= chk_fmt;
        s1_err_q <= chk_err;
      end
    end
  end

  // S2 assembly mux; errored words become all-zero.
  always_comb begin
    asm_inst = '0;
    case (s1_fmt_q)
      FMT_R:   asm_inst = {s1_f7_q, s1_rs2_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, 2'b11};
      FMT_I:   asm_inst = {s1_imm_q[11:0], s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, 2'b11};
      FMT_S:   asm_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_f3_q, s1_imm_q[4:0],
                           s1_op_q, 2'b11};
      FMT_B:   asm_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_f3_q,
                           s1_imm_q[4:1], s1_imm_q[11], s1_op_q, 2'b11};
      FMT_U:   asm_inst = {s1_imm_q[31:12], s1_rd_q, s1_op_q, 2'b11};
      FMT_J:   asm_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                           s1_rd_q, s1_op_q, 2'b11};
      FMT_SYS: asm_inst = {s1_f12_q, s1_rs1_q, s1_f3_q, s1_rd_q, s1_op_q, 2'b11};
      default: asm_inst = '0;
    endcase
    if (s1_err_q != ERR_NONE) asm_inst = '0;
  end

  // S2: output register; contents only change when S2 loads, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_err_q   <= 1'b0;
      out_code_q  <= '0;
    end else if (s2_load) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_inst_q <= asm_inst;
        out_err_q  <= (s1_err_q != ERR_NONE);
        out_code_q <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (cnt_clr) begin
      cnt_ok_q  <= '0;
      cnt_err_q <= '0;
    end else if (out_fire) begin
      if (out_err_q) cnt_err_q <= cnt_err_q + CNT_W'(1);
      else           cnt_ok_q  <= cnt_ok_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors, counter clear, randomized streams against an
// arithmetic reference model with an occupancy-based handshake model, and reset mid-flight.
module tb_inst_encoder;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] f12;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [1:0]  code;
    int          acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cnt_clr;
  logic [15:0] cnt_ok;
  logic [15:0] cnt_err;

  int passed  = 0;
  int total   = 0;
  int exp_ok  = 0;
  int exp_err = 0;

  inst_encoder_if bus ();

  inst_encoder #(
    .CNT_W      (16),
    .RANGE_CHECK(1'b1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .cnt_clr(cnt_clr),
    .cnt_ok (cnt_ok),
    .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic req_t mk(input logic [4:0] op, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [2:0] f3);
    req_t r;
    r.op = op; r.imm = imm; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.f3 = f3;
    r.f7 = 7'h00; r.f12 = 12'h000;
    return r;
  endfunction

  // Reference model: format letter from the opcode table, range tests on the signed integer
  // value, word built by shifting each field to its bit position.
  function automatic exp_t model(input req_t r);
    exp_t e;
    byte f;
    int s;
    logic [31:0] base, op_rd, src;
    s     = $signed(r.imm);
    base  = 32'(r.op) * 4 + 3;
    op_rd = (32'(r.rd) << 7) | base;
    src   = (32'(r.rs1) << 15) | (32'(r.f3) << 12);
    case (r.op)
      5'b01100:                   f = "R";
      5'b00000, 5'b00100, 5'b11001: f = "I";
      5'b01000:                   f = "S";
      5'b11000:                   f = "B";
      5'b01101, 5'b00101:         f = "U";
      5'b11011:                   f = "J";
      5'b11100, 5'b00011:         f = "Y";
      default:                    f = "?";
    endcase
    e.code = 2'd0;
    e.inst = 32'h0;
    e.acc_cyc = 0;
    case (f)
      "?": e.code = 2'd1;
      "I", "S": if (s < -2048 || s > 2047) e.code = 2'd3;
      "B": begin
        if (s % 2 != 0) e.code = 2'd2;
        else if (s < -4096 || s > 4095) e.code = 2'd3;
      end
      "J": begin
        if (s % 2 != 0) e.code = 2'd2;
        else if (s < -(1 << 20) || s > (1 << 20) - 1) e.code = 2'd3;
      end
      "U": if (r.imm % 4096 != 0) e.code = 2'd2;
      default: ;
    endcase
    case (f)
      "R": e.inst = (32'(r.f7) << 25) | (32'(r.rs2) << 20) | src | op_rd;
      "I": e.inst = ((r.imm & 32'hfff) << 20) | src | op_rd;
      "S": e.inst = (((r.imm >> 5) & 32'h7f) << 25) | (32'(r.rs2) << 20) | src
                    | ((r.imm & 32'h1f) << 7) | base;
      "B": e.inst = (((r.imm >> 12) & 32'h1) << 31) | (((r.imm >> 5) & 32'h3f) << 25)
                    | (32'(r.rs2) << 20) | src | (((r.imm >> 1) & 32'hf) << 8)
                    | (((r.imm >> 11) & 32'h1) << 7) | base;
      "U": e.inst = (r.imm & 32'hffff_f000) | op_rd;
      "J": e.inst = (((r.imm >> 20) & 32'h1) << 31) | (((r.imm >> 1) & 32'h3ff) << 21)
                    | (((r.imm >> 11) & 32'h1) << 20) | (((r.imm >> 12) & 32'hff) << 12) | op_rd;
      "Y": e.inst = (32'(r.f12) << 20) | src | op_rd;
      default: e.inst = 32'h0;
    endcase
    e.err = (e.code != 2'd0);
    if (e.err) e.inst = 32'h0;
    return e;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    logic [4:0] legal [11];
    legal = '{5'b01100, 5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000,
              5'b01101, 5'b00101, 5'b11011, 5'b11100, 5'b00011};
    if ($urandom_range(0, 9) == 0) r.op = 5'($urandom);
    else r.op = legal[$urandom_range(0, 10)];
    r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.rd = 5'($urandom);
    r.f3 = 3'($urandom); r.f7 = 7'($urandom); r.f12 = 12'($urandom);
    case ($urandom_range(0, 3))
      0:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1:       r.imm = $urandom;
      2:       r.imm = $urandom & 32'hffff_f000;
      default: r.imm = 32'($urandom_range(0, (1 << 21) - 1)) - 32'(1 << 20);
    endcase
    return r;
  endfunction

  task automatic drive(input req_t r, input logic v);
    bus.in_valid  = v;
    bus.in_opcode = r.op;
    bus.in_imm    = r.imm;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_rd     = r.rd;
    bus.in_func3  = r.f3;
    bus.in_func7  = r.f7;
    bus.in_func12 = r.f12;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    bus.out_ready = 1'b0;
    drive(mk(5'd0, 32'd0, 5'd0, 5'd0, 5'd0, 3'd0), 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); else passed++;
    total++; if (bus.out_inst !== 32'h0) $display("FAIL reset out_inst got=%h exp=0", bus.out_inst); else passed++;
    total++; if (bus.out_err !== 1'b0 || bus.out_err_code !== 2'b00)
      $display("FAIL reset out_err got=%b/%b exp=0/00", bus.out_err, bus.out_err_code); else passed++;
    total++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0)
      $display("FAIL reset counters got=%0d/%0d exp=0/0", cnt_ok, cnt_err); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got=%b exp=1", bus.in_ready); else passed++;
  endtask

  task automatic test_directed();
    req_t        r [8];
    logic [31:0] inst [8];
    logic [1:0]  code [8];
    r[0] = mk(5'b00100, 32'd5, 5'd0, 5'd0, 5'd1, 3'd0);    inst[0] = 32'h00500093; code[0] = 2'd0;
    r[1] = mk(5'b01000, 32'd8, 5'd1, 5'd2, 5'd0, 3'd2);    inst[1] = 32'h0020A423; code[1] = 2'd0;
    r[2] = mk(5'b11011, 32'd8, 5'd0, 5'd0, 5'd1, 3'd0);    inst[2] = 32'h008000EF; code[2] = 2'd0;
    r[3] = mk(5'b01101, 32'h12345000, 5'd0, 5'd0, 5'd5, 3'd0); inst[3] = 32'h123452B7; code[3] = 2'd0;
    r[4] = mk(5'b11000, 32'd3, 5'd1, 5'd2, 5'd0, 3'd0);    inst[4] = 32'h0; code[4] = 2'd2;
    r[5] = mk(5'b00100, 32'd2048, 5'd0, 5'd0, 5'd1, 3'd0); inst[5] = 32'h0; code[5] = 2'd3;
    r[6] = mk(5'b11111, 32'd0, 5'd0, 5'd0, 5'd1, 3'd0);    inst[6] = 32'h0; code[6] = 2'd1;
    r[7] = mk(5'b01100, 32'd0, 5'd1, 5'd2, 5'd3, 3'd0);    inst[7] = 32'h002081B3; code[7] = 2'd0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(r[i], 1'b1);
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL directed[%0d] in_ready got=%b exp=1", i, bus.in_ready); else passed++;
      @(negedge clk);
      drive(r[i], 1'b0);
      #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL directed[%0d] early out_valid got=%b exp=0", i, bus.out_valid); else passed++;
      @(negedge clk);
      #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_inst !== inst[i] || bus.out_err !== (code[i] != 2'd0)
          || bus.out_err_code !== code[i])
        $display("FAIL directed[%0d] result got v=%b inst=%h err=%b code=%b exp v=1 inst=%h code=%b",
                 i, bus.out_valid, bus.out_inst, bus.out_err, bus.out_err_code, inst[i], code[i]);
      else passed++;
      if (code[i] == 2'd0) exp_ok++; else exp_err++;
      @(negedge clk);
      #1;
      total++;
      if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err))
        $display("FAIL directed[%0d] counters got=%0d/%0d exp=%0d/%0d", i, cnt_ok, cnt_err, exp_ok, exp_err);
      else passed++;
    end
  endtask

  // Clear asserted in the same cycle as an output handshake: the clear must win.
  task automatic test_counter_clear();
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(mk(5'b00100, 32'd1, 5'd0, 5'd0, 5'd2, 3'd0), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    exp_ok = 0;
    exp_err = 0;
    #1;
    total++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0)
      $display("FAIL clear_vs_inc counters got=%0d/%0d exp=0/0", cnt_ok, cnt_err); else passed++;
  endtask

  // Randomized stream. A word accepted in cycle c reaches the output in cycle c+2 at the
  // earliest; the encoder holds at most two words, so in_ready is low only when two are held
  // and the consumer is not taking one.
  task automatic test_stream(input string name, input int n, input int vpct, input int rpct,
                             input int stall_at, input int stall_len, output int cycles);
    exp_t q[$];
    exp_t e;
    req_t r;
    int sent = 0, got = 0, cyc = 0;
    bit pending = 0, stalled = 0;
    bit exp_ir, exp_ov;
    logic [31:0] h_inst;
    logic h_err;
    logic [1:0] h_code;
    r = rand_req();
    while (got < n && cyc < n * 20 + 100) begin
      @(negedge clk);
      if (!pending) drive(r, (sent < n) && ($urandom_range(0, 99) < vpct));
      if (cyc >= stall_at && cyc < stall_at + stall_len) bus.out_ready = 1'b0;
      else bus.out_ready = ($urandom_range(0, 99) < rpct);
      #1;
      exp_ir = (q.size() < 2) || bus.out_ready;
      exp_ov = (q.size() > 0) && (q[0].acc_cyc + 2 <= cyc);
      total++; if (bus.in_ready !== exp_ir)
        $display("FAIL %s in_ready cyc=%0d got=%b exp=%b", name, cyc, bus.in_ready, exp_ir); else passed++;
      total++; if (bus.out_valid !== exp_ov)
        $display("FAIL %s out_valid cyc=%0d got=%b exp=%b", name, cyc, bus.out_valid, exp_ov); else passed++;
      if (stalled) begin
        total++;
        if (bus.out_inst !== h_inst || bus.out_err !== h_err || bus.out_err_code !== h_code)
          $display("FAIL %s stall_hold cyc=%0d got=%h/%b/%b exp=%h/%b/%b", name, cyc,
                   bus.out_inst, bus.out_err, bus.out_err_code, h_inst, h_err, h_code);
        else passed++;
      end
      if (exp_ov && bus.out_ready) begin
        e = q.pop_front();
        total++;
        if (bus.out_inst !== e.inst || bus.out_err !== e.err || bus.out_err_code !== e.code)
          $display("FAIL %s word%0d got inst=%h err=%b code=%b exp inst=%h err=%b code=%b", name,
                   got, bus.out_inst, bus.out_err, bus.out_err_code, e.inst, e.err, e.code);
        else passed++;
        if (e.err) exp_err++; else exp_ok++;
        got++;
      end
      if (bus.in_valid && exp_ir) begin
        e = model(r);
        e.acc_cyc = cyc;
        q.push_back(e);
        sent++;
        pending = 0;
        r = rand_req();
      end else begin
        pending = bus.in_valid;
      end
      stalled = exp_ov && !bus.out_ready;
      h_inst = bus.out_inst; h_err = bus.out_err; h_code = bus.out_err_code;
      cyc++;
    end
    total++; if (got != n) $display("FAIL %s timeout words got=%0d exp=%0d", name, got, n); else passed++;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err))
      $display("FAIL %s counters got=%0d/%0d exp=%0d/%0d", name, cnt_ok, cnt_err, exp_ok, exp_err);
    else passed++;
    cycles = cyc;
  endtask

  task automatic test_backpressure();
    int cyc;
    test_stream("backpressure", 8, 100, 100, 3, 5, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    test_stream("throughput", 100, 100, 100, -1, 0, cyc);
    total++; if (cyc != 102) $display("FAIL throughput cycles got=%0d exp=102", cyc); else passed++;
  endtask

  task automatic test_random();
    int cyc;
    test_stream("random", 2000, 60, 60, -1, 0, cyc);
    test_stream("random_slow_sink", 500, 100, 30, -1, 0, cyc);
  endtask

  task automatic test_reset_midflight();
    bit seen = 0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    drive(mk(5'b00100, 32'd7, 5'd1, 5'd0, 5'd4, 3'd0), 1'b1);
    @(negedge clk);
    drive(mk(5'b01101, 32'h0000_1000, 5'd0, 5'd0, 5'd6, 3'd0), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
      $display("FAIL midreset full got v=%b rdy=%b exp v=1 rdy=0", bus.out_valid, bus.in_ready); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_inst !== 32'h0)
      $display("FAIL midreset outputs got v=%b inst=%h exp v=0 inst=0", bus.out_valid, bus.out_inst); else passed++;
    total++; if (cnt_ok !== 16'h0 || cnt_err !== 16'h0)
      $display("FAIL midreset counters got=%0d/%0d exp=0/0", cnt_ok, cnt_err); else passed++;
    exp_ok = 0;
    exp_err = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    total++; if (seen) $display("FAIL midreset emitted got out_valid=1 after release exp none"); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_counter_clear();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
